// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-stage state type for ahb_lite_master.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2
  } hsize_t;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // Data-stage state: no data phase, data phase in progress, second ERROR cycle.
  typedef enum logic [1:0] {
    D_IDLE,
    D_BUSY,
    D_ERR
  } d_state_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: one command register (A) feeding the address phase and one
// data-stage register (D) tracking the overlapped data phase. Single transfers only.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response port
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  // AHB-Lite master side
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  // Address stage (A)
  logic              a_v;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_size;
  logic [DATA_W-1:0] a_wdata;

  // Data stage (D); HWDATA itself is the stored write data
  d_state_t d_state, d_next;
  logic     d_write;

  logic addr_issue;  // NONSEQ is on the bus this cycle
  logic a_adv;       // address phase completes at the coming edge
  logic cmd_fire;
  logic d_done;      // data phase completes at the coming edge
  logic d_fail;      // ... with an ERROR response

  // Address-phase control: an ERROR in flight cancels the pipelined address.
  always_comb begin
    addr_issue = a_v && (d_state != D_ERR) && !((d_state == D_BUSY) && HRESP);
    a_adv      = addr_issue && HREADY;
    cmd_fire   = cmd_valid && cmd_ready;
  end

  assign cmd_ready = !a_v || a_adv;
  assign HTRANS    = addr_issue ? NONSEQ : IDLE;
  // A only reloads on a handshake, so these hold their values through IDLE cycles.
  assign HADDR     = a_addr;
  assign HWRITE    = a_write;
  assign HSIZE     = a_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

  // Address stage register: load on handshake, drain when the address phase ends.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      a_v     <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
      a_size  <= '0;
      a_wdata <= '0;
    end else if (cmd_fire) begin
      a_v     <= 1'b1;
      a_write <= cmd_write;
      a_addr  <= cmd_addr;
      a_size  <= cmd_size;
      a_wdata <= cmd_wdata;
    end else if (a_adv) begin
      a_v <= 1'b0;
    end
  end

  // Data-stage next state and completion decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    d_next = d_state;
    d_done = 1'b0;
    d_fail = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (a_adv) d_next = D_BUSY;
      end
      D_BUSY: begin
        if (HREADY) begin
          // HRESP with HREADY high is a slave protocol violation; treat as error.
          d_done = 1'b1;
          d_fail = HRESP;
          d_next = a_adv ? D_BUSY : D_IDLE;
        end else if (HRESP) begin
          d_next = D_ERR;
        end
      end
      D_ERR: begin
        if (HREADY) begin
          d_done = 1'b1;
          d_fail = 1'b1;
          d_next = D_IDLE;
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  // Data stage register: state, direction and write data of the active data phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_state <= D_IDLE;
      d_write <= 1'b0;
      HWDATA  <= '0;
    end else begin
      d_state <= d_next;
      if (a_adv) begin
        d_write <= a_write;
        if (a_write) HWDATA <= a_wdata;
      end
    end
  end

  // Registered response, issued the cycle after the data phase completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= d_done;
      if (d_done) begin
        rsp_error <= d_fail;
        rsp_rdata <= d_write ? '0 : HRDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master; the bench scripts the slave handshake per cycle.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahb_lite_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wd;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) tick();

    // Reset state
    @(negedge clk);
    check("rst htrans", HTRANS, IDLE);
    check("rst haddr", HADDR, 0);
    check("rst hwrite", HWRITE, 0);
    check("rst hsize", HSIZE, 0);
    check("rst hwdata", HWDATA, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_rdata", rsp_rdata, 0);
    check("rst rsp_error", rsp_error, 0);
    check("hburst", HBURST, 3'b000);
    check("hprot", HPROT, 4'b0011);
    check("hmastlock", HMASTLOCK, 0);
    reset = 1'b0;
    tick();

    // Single write, zero-wait
    offer(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr ready", cmd_ready, 1);
    check("wr pre htrans", HTRANS, IDLE);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("wr htrans", HTRANS, NONSEQ);
    check("wr haddr", HADDR, 32'h10);
    check("wr hwrite", HWRITE, 1);
    check("wr hsize", HSIZE, 2);
    tick();
    @(negedge clk);
    check("wr data htrans", HTRANS, IDLE);
    check("wr hwdata", HWDATA, 32'hDEAD_BEEF);
    check("wr early rsp", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("wr rsp_valid", rsp_valid, 1);
    check("wr rsp_error", rsp_error, 0);
    check("wr rsp_rdata", rsp_rdata, 0);
    tick();
    @(negedge clk);
    check("wr rsp pulse", rsp_valid, 0);
    tick();

    // Single read
    offer(1'b0, 32'h14, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rd htrans", HTRANS, NONSEQ);
    check("rd haddr", HADDR, 32'h14);
    check("rd hwrite", HWRITE, 0);
    tick();
    HRDATA = 32'h1234_5678;
    tick();
    HRDATA = '0;
    @(negedge clk);
    check("rd rsp_valid", rsp_valid, 1);
    check("rd rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("rd rsp_error", rsp_error, 0);
    tick();

    // Back-to-back writes 0x0, 0x4, 0x8, 0xC
    for (int c = 0; c < 8; c++) begin
      if (c < 4) offer(1'b1, 32'(c * 4), 3'd2, 32'hA000_0000 + 32'(c));
      else cmd_valid = 1'b0;
      @(negedge clk);
      if (c < 4) check($sformatf("b2b ready c%0d", c), cmd_ready, 1);
      check($sformatf("b2b htrans c%0d", c), HTRANS, (c >= 1 && c <= 4) ? NONSEQ : IDLE);
      if (c >= 1 && c <= 4) check($sformatf("b2b haddr c%0d", c), HADDR, 32'((c - 1) * 4));
      if (c >= 2 && c <= 5)
        check($sformatf("b2b hwdata c%0d", c), HWDATA, 32'hA000_0000 + 32'(c - 2));
      check($sformatf("b2b rsp c%0d", c), rsp_valid, (c >= 3 && c <= 6) ? 1 : 0);
      tick();
    end

    // Wait states: read 0x20 stalled twice while write 0x24 is queued
    offer(1'b0, 32'h20, 3'd2, 32'h0);
    tick();
    offer(1'b1, 32'h24, 3'd2, 32'h0000_55AA);
    @(negedge clk);
    check("ws rd haddr", HADDR, 32'h20);
    check("ws ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      HREADY = 1'b0;
      @(negedge clk);
      check($sformatf("ws htrans w%0d", w), HTRANS, NONSEQ);
      check($sformatf("ws haddr w%0d", w), HADDR, 32'h24);
      check($sformatf("ws ready w%0d", w), cmd_ready, 0);
      check($sformatf("ws rsp w%0d", w), rsp_valid, 0);
      tick();
    end
    HREADY = 1'b1;
    HRDATA = 32'hCAFE_F00D;
    @(negedge clk);
    check("ws release ready", cmd_ready, 1);
    tick();
    HRDATA = '0;
    @(negedge clk);
    check("ws rd rsp_valid", rsp_valid, 1);
    check("ws rd rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("ws wr hwdata", HWDATA, 32'h0000_55AA);
    tick();
    @(negedge clk);
    check("ws wr rsp_valid", rsp_valid, 1);
    check("ws wr rsp_rdata", rsp_rdata, 0);
    check("ws wr rsp_error", rsp_error, 0);
    tick();

    // ERROR on write 0x30 with read 0x34 pipelined
    offer(1'b1, 32'h30, 3'd2, 32'h0000_0BAD);
    tick();
    offer(1'b0, 32'h34, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge clk);
    check("err1 htrans", HTRANS, IDLE);
    check("err1 ready", cmd_ready, 0);
    check("err1 hwdata", HWDATA, 32'h0000_0BAD);
    tick();
    HREADY = 1'b1; HRESP = 1'b1;
    @(negedge clk);
    check("err2 htrans", HTRANS, IDLE);
    check("err2 ready", cmd_ready, 0);
    tick();
    HRESP = 1'b0;
    @(negedge clk);
    check("err rsp_valid", rsp_valid, 1);
    check("err rsp_error", rsp_error, 1);
    check("err reissue htrans", HTRANS, NONSEQ);
    check("err reissue haddr", HADDR, 32'h34);
    check("err reissue hwrite", HWRITE, 0);
    tick();
    HRDATA = 32'h7777_0034;
    @(negedge clk);
    check("err gap rsp", rsp_valid, 0);
    tick();
    HRDATA = '0;
    @(negedge clk);
    check("err rd rsp_valid", rsp_valid, 1);
    check("err rd rsp_rdata", rsp_rdata, 32'h7777_0034);
    check("err rd rsp_error", rsp_error, 0);
    tick();

    // Reset during the data phase of a read
    offer(1'b0, 32'h40, 3'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    HRDATA = 32'h0000_0099;
    tick();
    reset = 1'b0;
    HRDATA = '0;
    @(negedge clk);
    check("mr rsp_valid", rsp_valid, 0);
    check("mr htrans", HTRANS, IDLE);
    check("mr haddr", HADDR, 0);
    check("mr hwrite", HWRITE, 0);
    check("mr hsize", HSIZE, 0);
    check("mr hwdata", HWDATA, 0);
    check("mr rsp_rdata", rsp_rdata, 0);
    check("mr rsp_error", rsp_error, 0);
    check("mr ready", cmd_ready, 1);
    tick();
    @(negedge clk);
    check("mr no late rsp", rsp_valid, 0);
    tick();
    offer(1'b0, 32'h48, 3'd1, 32'h0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mr new htrans", HTRANS, NONSEQ);
    check("mr new haddr", HADDR, 32'h48);
    check("mr new hsize", HSIZE, 1);
    tick();
    HRDATA = 32'hABCD_0123;
    tick();
    HRDATA = '0;
    @(negedge clk);
    check("mr new rsp_valid", rsp_valid, 1);
    check("mr new rsp_rdata", rsp_rdata, 32'hABCD_0123);
    check("mr new rsp_error", rsp_error, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite initiator that turns single-transfer read/write commands from a simple valid/ready command port into pipelined AHB-Lite NONSEQ/SINGLE transfers and returns one response per command. It is the bus-master end of the `ahb_intf` bus and drives the same slave-side `wrapper` that the test environment exercises. It supports overlapped address/data phases, wait states and the two-cycle ERROR response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 only)
- clk  in  1  bus clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready at clock edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address, passed unmodified to HADDR
- cmd_size  in  3  HSIZE encoding, 0..2 only
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_W  read data, 0 for writes
- rsp_error  out  1  transfer got ERROR response
- HADDR  out  ADDR_W;  HTRANS  out  2;  HWRITE  out  1;  HSIZE  out  3
- HBURST  out  3  constant SINGLE (000);  HPROT  out  4  constant 0011;  HMASTLOCK  out  1  constant 0
- HWDATA  out  DATA_W  data-phase write data
- HRDATA  in  DATA_W;  HREADY  in  1;  HRESP  in  1  (0 OKAY, 1 ERROR)

## Operation
- **Address stage register (A):**
  - Holds one accepted command plus a valid bit a_v.
  - cmd_ready = !a_v || (HREADY && !(d_v && HRESP)).
  - Handshake loads A, or replaces A in the same edge on which A advances.
- **Address phase:**
  - HTRANS = NONSEQ when a_v and not (d_v && HRESP); otherwise IDLE.
  - HADDR, HWRITE and HSIZE come from A.
  - When HTRANS is IDLE, HADDR, HWRITE and HSIZE hold their last values.
  - The phase ends on an edge with HREADY=1 while HTRANS=NONSEQ. A then moves to the data stage register D (d_v=1), and a_v clears unless refilled.
- **Data stage D, FSM:**
  - D_IDLE: no data phase.
  - D_BUSY: data phase active; HWDATA = D.wdata for writes, otherwise holds.
  - D_BUSY, HREADY=1, HRESP=0: complete OKAY. Go to D_BUSY if A advances on the same edge, else D_IDLE.
  - D_BUSY, HREADY=0, HRESP=1: go to D_ERR (first error cycle). HTRANS is driven IDLE combinationally in this cycle, which cancels any pipelined A.
  - D_ERR: HTRANS=IDLE. On HREADY=1, complete with error and go to D_IDLE. A is kept and reissued as NONSEQ on the following cycle.
  - HRESP=1 with HREADY=1 in D_BUSY is a protocol violation. It completes as an error.
- **Response:**
  - Registered. rsp_valid=1 in the cycle after the completing edge.
  - rsp_rdata captures HRDATA on reads and is 0 on writes.
  - rsp_error reflects the ERROR response.
  - Responses are issued in command order, one per command.
- **Reset:**
  - a_v=0, d_v=0, FSM=D_IDLE.
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - Reset mid-transfer drops all outstanding commands without responses. HTRANS is IDLE from the first cycle after the reset edge.

## Timing
- Handshake at edge E0. Address phase in cycle E0–E1. Data phase in cycle E1–E2 if zero-wait. rsp_valid is high in the cycle after E2.
- Minimum latency: 3 cycles from handshake to rsp_valid.
- Throughput: one transfer per cycle with continuous cmd_valid and HREADY=1.
- Each wait state (HREADY=0) stretches both the data phase and the overlapped address phase by one cycle. cmd_ready stays low while a_v=1.
- ERROR adds one extra idle address cycle before the cancelled command is reissued.
- Combinational paths:
  - HRESP -> HTRANS and HRESP/HREADY -> cmd_ready.
  - No combinational path from cmd_* to AHB outputs.

## Structure
- Package ahb_pkg holds:
  - htrans_t enum: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - hsize_t: BYTE=0, HALF=1, WORD=2.
  - Constants HBURST_SINGLE=3'b000 and HPROT_DATA_PRIV=4'b0011.
  - Data-stage FSM enum: D_IDLE, D_BUSY, D_ERR.
- Single module, no sub-module. A and D are small register groups within it.

## Test plan
- **Single write:** addr 0x0000_0010, wdata 0xDEAD_BEEF, size 2, zero-wait slave -> NONSEQ/HWRITE=1 for 1 cycle, HWDATA=0xDEAD_BEEF in the next cycle, rsp_valid 3 cycles after handshake, rsp_error=0.
- **Single read:** addr 0x14, slave returns 0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_error=0.
- **Back-to-back:** 4 writes to 0x0, 0x4, 0x8, 0xC with cmd_valid held high -> 4 consecutive NONSEQ cycles, HWDATA lagging HADDR by 1 cycle, 4 consecutive rsp_valid pulses.
- **Wait states:** read at 0x20 with 2 HREADY=0 cycles while a write to 0x24 is queued -> HADDR holds 0x24 and cmd_ready stays 0 for 2 cycles; responses arrive in order, read first.
- **Error:** write to 0x30 gets ERROR while a read of 0x34 is pipelined -> HTRANS=IDLE in both error cycles, rsp_error=1 for 0x30, read 0x34 reissued next cycle and completes OKAY.
- **Reset mid-read:** reset=1 for 1 cycle during a data phase -> no rsp_valid, HTRANS=IDLE, all outputs at reset values; a new command after reset completes normally.
